alu_muldiv: RTL

- Next-generation execution unit for the NPC core. Replaces the single-op combinational ALU.
- Covers all RV32I/RV64I OP and OP-IMM integer ops, plus the M-extension multiply/divide.
- Width is a parameter. Multiply and divide are iterative shift-add / restoring engines.
- Sits between decode and writeback, with a valid/ready handshake on both sides.

---
 rtl/alu_muldiv.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Integer execution unit: single-cycle RV32I/RV64I OP/OP-IMM ops plus iterative
// M-extension multiply (shift-add) and divide (restoring), valid/ready on both sides.
module alu_muldiv #(
    parameter int WORD_LENGTH = 32,
    parameter int SHAMT_BITS  = $clog2(WORD_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic [6:0]             funct7,
    input  logic [WORD_LENGTH-1:0] src1,
    input  logic [WORD_LENGTH-1:0] src2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] result,
    output logic                   illegal
);
    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(WORD_LENGTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [W-1:0]     result_reg;
    logic             illegal_reg;
    logic [CW-1:0]    cnt_reg;
    logic [2:0]       f3_reg;
    logic             neg_reg;
    // Multiply: acc = running product, addend = shifting multiplicand, shf = multiplier.
    // Divide:   acc[W-1:0] = partial remainder, addend[W-1:0] = divisor, shf = dividend/quotient.
    logic [2*W-1:0]   acc_reg;
    logic [2*W-1:0]   addend_reg;
    logic [W-1:0]     shf_reg;

    logic             is_op, is_imm, is_base, is_mext;
    logic             div_zero, div_ovf, is_special;
    logic             sgn1, sgn2, neg1, neg2;
    logic [W-1:0]     mag1, mag2;
    logic [SHAMT_BITS-1:0] shamt;
    logic [W-1:0]     sra_res;
    logic [W-1:0]     base_res, spec_res, quick_res;
    logic             quick_illegal;

    logic [2*W-1:0]   acc_mul, prod;
    logic [W:0]       rem_shift, trial;
    logic             take;
    logic [W-1:0]     rem_next, quo_next, quo_s, rem_s, mul_res, final_res;

    assign shamt   = src2[SHAMT_BITS-1:0];
    assign sra_res = $signed(src1) >>> shamt;

    always_comb begin
        is_op   = (opcode == 7'b0110011);
        is_imm  = (opcode == 7'b0010011);
        is_base = is_imm || (is_op && (funct7 == 7'b0000000 || funct7 == 7'b0100000));
        is_mext = is_op && (funct7 == 7'b0000001);

        case (funct3)
            3'b000:  base_res = (is_op && funct7[5]) ? src1 - src2 : src1 + src2;
            3'b001:  base_res = src1 << shamt;
            3'b010:  base_res = {{(W-1){1'b0}}, $signed(src1) < $signed(src2)};
            3'b011:  base_res = {{(W-1){1'b0}}, src1 < src2};
            3'b100:  base_res = src1 ^ src2;
            3'b101:  base_res = funct7[5] ? sra_res : src1 >> shamt;
            3'b110:  base_res = src1 | src2;
            default: base_res = src1 & src2;
        endcase

        // Division shortcuts never enter the iterative engine.
        div_zero   = (src2 == '0);
        div_ovf    = !funct3[0] && (src1 == MOST_NEG) && (src2 == '1);
        is_special = is_mext && funct3[2] && (div_zero || div_ovf);
        if (funct3[1])
            spec_res = div_zero ? src1 : '0;
        else
            spec_res = div_zero ? '1 : src1;

        quick_illegal = 1'b0;
        if (is_base)
            quick_res = base_res;
        else if (is_mext)
            quick_res = spec_res;
        else begin
            quick_res     = '0;
            quick_illegal = 1'b1;
        end

        // Plain mul only needs the low half, which is sign-agnostic.
        sgn1 = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn2 = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg1 = sgn1 && src1[W-1];
        neg2 = sgn2 && src2[W-1];
        mag1 = neg1 ? -src1 : src1;
        mag2 = neg2 ? -src2 : src2;
    end

    always_comb begin
        acc_mul   = shf_reg[0] ? acc_reg + addend_reg : acc_reg;
        rem_shift = {acc_reg[W-1:0], shf_reg[W-1]};
        trial     = rem_shift - {1'b0, addend_reg[W-1:0]};
        take      = !trial[W];
        rem_next  = take ? trial[W-1:0] : rem_shift[W-1:0];
        quo_next  = {shf_reg[W-2:0], take};

        prod    = neg_reg ? -acc_mul : acc_mul;
        mul_res = (f3_reg[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        quo_s   = neg_reg ? -quo_next : quo_next;
        rem_s   = neg_reg ? -rem_next : rem_next;
        if (!f3_reg[2])
            final_res = mul_res;
        else
            final_res = f3_reg[1] ? rem_s : quo_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            illegal_reg   <= 1'b0;
            cnt_reg       <= '0;
            f3_reg        <= '0;
            neg_reg       <= 1'b0;
            acc_reg       <= '0;
            addend_reg    <= '0;
            shf_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    out_valid_reg <= 1'b0;
                    if (in_valid && !flush) begin
                        f3_reg       <= funct3;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        if (is_mext && !is_special) begin
                            state_reg <= BUSY;
                            acc_reg   <= '0;
                            neg_reg   <= (funct3[2] && funct3[1]) ? neg1 : (neg1 ^ neg2);
                            if (funct3[2]) begin
                                addend_reg <= {{W{1'b0}}, mag2};
                                shf_reg    <= mag1;
                            end else begin
                                addend_reg <= {{W{1'b0}}, mag1};
                                shf_reg    <= mag2;
                            end
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= quick_res;
                            illegal_reg   <= quick_illegal;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                        cnt_reg      <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (f3_reg[2]) begin
                            acc_reg <= {{W{1'b0}}, rem_next};
                            shf_reg <= quo_next;
                        end else begin
                            acc_reg    <= acc_mul;
                            addend_reg <= addend_reg << 1;
                            shf_reg    <= shf_reg >> 1;
                        end
                        if (cnt_reg == CNT_LAST) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= final_res;
                            illegal_reg   <= 1'b0;
                            cnt_reg       <= '0;
                        end
                    end
                end
                default: begin
                    if (flush || out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign illegal   = illegal_reg;
endmodule
